// File: rtl/riscv_pipe_pkg.sv
// Shared pipeline definitions: datapath width, NOP encoding, default reset PC
// and the IF/ID payload layout.
package riscv_pipe_pkg;

  localparam int unsigned XLEN             = 32;
  localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [31:0]     instr;
  } if_id_t;

endpackage

// File: rtl/fetch_buf.sv
// Small synchronous FIFO used for the fetched-instruction buffer and the
// in-flight PC queue. Flush wins over push/pop.
module fetch_buf #(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic                       pop,
  input  logic                       flush,
  input  logic [WIDTH-1:0]           din,
  output logic [$clog2(DEPTH):0]     count,
  output logic [WIDTH-1:0]           head
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    wr_ptr;

  // Pointer and occupancy tracking; pointers wrap naturally (DEPTH is 2^AW)
  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage array, written on accepted push
  always_ff @(posedge clk) begin
    if (push && !flush) mem[wr_ptr] <= din;
  end

  assign head = mem[rd_ptr];

endmodule

// File: rtl/fetch_stall_stage.sv
// Fetch stage: PC generation, imem request issue under a credit rule,
// response buffering, IF/ID register with stall hold and redirect flush.
// Optional perf counters are built when FETCH_PERF_CNT_EN is defined.
module fetch_stall_stage #(
  parameter int unsigned     XLEN      = 32,
  parameter logic [XLEN-1:0] RESET_PC  = '0,
  parameter int unsigned     BUF_DEPTH = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            stall,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_gnt,
  input  logic            imem_rvalid,
  input  logic [31:0]     imem_rdata,
  output logic            if_id_valid,
  output logic [XLEN-1:0] if_id_pc,
  output logic [31:0]     if_id_instr,
`ifdef FETCH_PERF_CNT_EN
  output logic [31:0]     perf_stall_cycles,
  output logic [31:0]     perf_flush_count,
  output logic [31:0]     perf_drop_count,
`endif
  output logic            id_ex_bubble
);

  import riscv_pipe_pkg::*;

  localparam int unsigned CW = $clog2(BUF_DEPTH) + 1;

  logic [XLEN-1:0] pc;
  logic            run;
  logic [CW-1:0]   drop_cnt;
  logic [CW-1:0]   ibuf_count;
  logic [CW-1:0]   pcq_count;
  logic [CW-1:0]   outstanding;
  logic [CW:0]     credit_used;
  logic [XLEN+31:0] ibuf_head;
  logic [XLEN-1:0] pcq_head;
  logic            accept;
  logic            resp_take;
  logic            resp_drop;
  logic            ibuf_pop;

  // Outstanding requests are either still expected (PC queue) or doomed
  // (drop_cnt), so no separate counter is kept.
  always_comb begin
    outstanding = pcq_count + drop_cnt;
    credit_used = {1'b0, ibuf_count} + {1'b0, outstanding};
    imem_req    = run && (credit_used < (CW+1)'(BUF_DEPTH)) && !redirect_valid;
    accept      = imem_req && imem_gnt;
    resp_take   = imem_rvalid && (drop_cnt == '0) && !redirect_valid;
    resp_drop   = imem_rvalid && ((drop_cnt != '0) || redirect_valid);
    ibuf_pop    = !redirect_valid && !stall && (ibuf_count != '0);
  end

  assign imem_addr    = pc;
  assign id_ex_bubble = stall || redirect_valid;

  fetch_buf #(.WIDTH(XLEN), .DEPTH(BUF_DEPTH)) u_pcq (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (accept),
    .pop   (resp_take),
    .flush (redirect_valid),
    .din   (pc),
    .count (pcq_count),
    .head  (pcq_head)
  );

  fetch_buf #(.WIDTH(XLEN + 32), .DEPTH(BUF_DEPTH)) u_ibuf (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (resp_take),
    .pop   (ibuf_pop),
    .flush (redirect_valid),
    .din   ({pcq_head, imem_rdata}),
    .count (ibuf_count),
    .head  (ibuf_head)
  );

  // PC, drop accounting and IF/ID register; redirect overrides stall
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc          <= RESET_PC;
      run         <= 1'b0;
      drop_cnt    <= '0;
      if_id_valid <= 1'b0;
      if_id_pc    <= '0;
      if_id_instr <= NOP_INSTR;
    end else begin
      run <= 1'b1;
      if (redirect_valid) begin
        pc          <= redirect_pc & ~XLEN'(3);
        drop_cnt    <= outstanding - CW'(imem_rvalid);
        if_id_valid <= 1'b0;
      end else begin
        if (accept)    pc       <= pc + XLEN'(4);
        if (resp_drop) drop_cnt <= drop_cnt - CW'(1);
        if (!stall) begin
          if (ibuf_count != '0) begin
            if_id_valid <= 1'b1;
            if_id_pc    <= ibuf_head[XLEN+31:32];
            if_id_instr <= ibuf_head[31:0];
          end else begin
            if_id_valid <= 1'b0;
          end
        end
      end
    end
  end

`ifdef FETCH_PERF_CNT_EN
  // Saturating performance counters
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      perf_stall_cycles <= '0;
      perf_flush_count  <= '0;
      perf_drop_count   <= '0;
    end else begin
      if (stall && if_id_valid && perf_stall_cycles != '1)
        perf_stall_cycles <= perf_stall_cycles + 32'd1;
      if (redirect_valid && perf_flush_count != '1)
        perf_flush_count <= perf_flush_count + 32'd1;
      if (resp_drop && perf_drop_count != '1)
        perf_drop_count <= perf_drop_count + 32'd1;
    end
  end
`else
  // Performance counters not built
`endif

endmodule

// File: tb/tb_fetch_stall_stage.sv
// Self-checking bench for fetch_stall_stage against a queue-based model.
module tb_fetch_stall_stage;
  import riscv_pipe_pkg::*;

  localparam int unsigned D = 2;

  logic        clk = 1'b0;
  logic        rst_n, stall, redirect_valid;
  logic [31:0] redirect_pc;
  logic        imem_req, imem_gnt, imem_rvalid;
  logic [31:0] imem_addr, imem_rdata;
  logic        if_id_valid, id_ex_bubble;
  logic [31:0] if_id_pc, if_id_instr;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_stall_cycles, perf_flush_count, perf_drop_count;
  int unsigned m_ps, m_pf, m_pd;
`endif

  always #5 clk = ~clk;

  fetch_stall_stage #(.XLEN(32), .RESET_PC(32'h0), .BUF_DEPTH(D)) dut (
    .clk(clk), .rst_n(rst_n), .stall(stall),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .if_id_valid(if_id_valid), .if_id_pc(if_id_pc), .if_id_instr(if_id_instr),
`ifdef FETCH_PERF_CNT_EN
    .perf_stall_cycles(perf_stall_cycles), .perf_flush_count(perf_flush_count),
    .perf_drop_count(perf_drop_count),
`endif
    .id_ex_bubble(id_ex_bubble)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // instruction memory environment
  typedef struct { logic [31:0] addr; int ready; } mreq_t;
  mreq_t mq[$];
  int    lat = 1;
  bit    rand_gnt = 1'b0;

  // reference model: in-flight fetches tagged stale after a redirect
  typedef struct { logic [31:0] pc; bit stale; } flight_t;
  flight_t     m_fl[$];
  logic [31:0] m_buf[$];
  logic [31:0] m_pc, m_ifpc, m_ifinstr;
  bit          m_run, m_ifv;

  function automatic logic [31:0] word_at(logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h0000_0013;
  endfunction

  function automatic int live_count();
    int n = 0;
    foreach (m_fl[i]) if (!m_fl[i].stale) n++;
    return n;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic timeout(input string tag);
    total++;
    bad++;
    $display("FAIL %s observed=timeout expected=condition", tag);
  endtask

  task automatic model_reset();
    m_fl.delete();
    m_buf.delete();
    m_pc = 32'h0; m_run = 1'b0; m_ifv = 1'b0;
    m_ifpc = 32'h0; m_ifinstr = NOP_INSTR;
`ifdef FETCH_PERF_CNT_EN
    m_ps = 0; m_pf = 0; m_pd = 0;
`endif
  endtask

  task automatic step(input bit rst_v, input bit st, input bit rd, input logic [31:0] rpc);
    logic    exp_req;
    flight_t h;
    rst_n = rst_v; stall = st; redirect_valid = rd; redirect_pc = rpc;
    imem_gnt = rand_gnt ? 1'($urandom_range(0, 1)) : 1'b1;
    imem_rvalid = 1'b0;
    if (rst_v && mq.size() > 0) imem_rvalid = (mq[0].ready <= cyc);
    imem_rdata = imem_rvalid ? word_at(mq[0].addr) : $urandom;
    #1;
    exp_req = m_run && (m_buf.size() + m_fl.size() < D) && !rd;
    chk("imem_req",     {31'b0, imem_req},     {31'b0, exp_req});
    chk("imem_addr",    imem_addr,             m_pc);
    chk("id_ex_bubble", {31'b0, id_ex_bubble}, {31'b0, st || rd});
    chk("if_id_valid",  {31'b0, if_id_valid},  {31'b0, m_ifv});
    chk("if_id_pc",     if_id_pc,              m_ifpc);
    chk("if_id_instr",  if_id_instr,           m_ifinstr);
`ifdef FETCH_PERF_CNT_EN
    chk("perf_stall", perf_stall_cycles, m_ps);
    chk("perf_flush", perf_flush_count,  m_pf);
    chk("perf_drop",  perf_drop_count,   m_pd);
`endif
    // environment memory reacts to what the DUT actually did
    if (!rst_v) mq.delete();
    else begin
      if (imem_rvalid) void'(mq.pop_front());
      if (imem_req && imem_gnt) mq.push_back('{imem_addr, cyc + lat});
    end
    // model update
    if (!rst_v) model_reset();
    else begin
`ifdef FETCH_PERF_CNT_EN
      if (st && m_ifv) m_ps++;
      if (rd) m_pf++;
      if (imem_rvalid && (rd || (m_fl.size() > 0 && m_fl[0].stale))) m_pd++;
`endif
      if (!rd && !st) begin
        if (m_buf.size() > 0) begin
          m_ifpc = m_buf.pop_front(); m_ifinstr = word_at(m_ifpc); m_ifv = 1'b1;
        end else m_ifv = 1'b0;
      end
      if (imem_rvalid && m_fl.size() > 0) begin
        h = m_fl.pop_front();
        if (!h.stale && !rd) m_buf.push_back(h.pc);
      end
      if (rd) begin
        m_buf.delete();
        foreach (m_fl[i]) m_fl[i].stale = 1'b1;
        m_ifv = 1'b0;
        m_pc = rpc & ~32'h3;
      end else if (exp_req && imem_gnt) begin
        m_fl.push_back('{m_pc, 1'b0});
        m_pc = m_pc + 32'd4;
      end
      m_run = 1'b1;
    end
    @(posedge clk); #1;
    cyc++;
  endtask

  initial begin
    int n;
    rst_n = 1'b0; stall = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
    imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;

    // 1: gnt=1, latency 1, no stall
    lat = 1; rand_gnt = 1'b0;
    repeat (12) step(1, 0, 0, 0);

    // 2: stall three cycles while IF/ID holds 0x8
    step(0, 0, 0, 0);
    n = 0;
    while (!(m_ifv && m_ifpc == 32'h8) && n < 20) begin step(1, 0, 0, 0); n++; end
    if (n >= 20) timeout("wait_ifpc_8");
    repeat (3) step(1, 1, 0, 0);
    chk("stall_hold_pc", if_id_pc, 32'h8);
    repeat (6) step(1, 0, 0, 0);

    // 3: redirect with two live requests in flight, latency 3
    lat = 3;
    n = 0;
    while (live_count() != 2 && n < 30) begin step(1, 0, 0, 0); n++; end
    if (n >= 30) timeout("wait_two_outstanding");
    step(1, 0, 1, 32'h100);
    chk("redir_addr", imem_addr, 32'h100);
    n = 0;
    while (!m_ifv && n < 30) begin step(1, 0, 0, 0); n++; end
    if (n >= 30) timeout("wait_first_after_redirect");
    chk("redir_first_pc", if_id_pc, 32'h100);
    repeat (4) step(1, 0, 0, 0);

    // 4: stall and redirect together
    step(1, 1, 1, 32'h100);
    chk("stall_redir_valid", {31'b0, if_id_valid}, 32'h0);
    chk("stall_redir_pc", imem_addr, 32'h100);
    repeat (6) step(1, 0, 0, 0);

    // 5: misaligned redirect target
    step(1, 0, 1, 32'h103);
    chk("align_addr", imem_addr, 32'h100);
    repeat (6) step(1, 0, 0, 0);

    // 6: reset mid-stream with buffer full
    lat = 1;
    n = 0;
    while (m_buf.size() != D && n < 20) begin step(1, 1, 0, 0); n++; end
    if (n >= 20) timeout("wait_buf_full");
    step(0, 1, 0, 0);
    chk("rst_instr", if_id_instr, NOP_INSTR);
    chk("rst_addr", imem_addr, 32'h0);
    repeat (8) step(1, 0, 0, 0);

    // randomized traffic
    rand_gnt = 1'b1;
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 15) == 0) lat = $urandom_range(1, 4);
      step(($urandom_range(0, 99) != 0),
           ($urandom_range(0, 3) == 0),
           ($urandom_range(0, 19) == 0),
           $urandom);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
